// File: rtl/nlc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : nlc_pkg                                                      |
// | Description : Shared widths, limits and FSM encoding for the SMC float     |
// |               to fixed-point count converter.                              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package nlc_pkg;

    localparam int SMC_EXP_BIAS = 127;
    localparam int SMC_W        = 32;
    localparam int X_W          = 21;
    localparam int X_MAX        = 1048575;
    localparam int X_MIN        = -1048576;

    // Saturation codes in the 21-bit two's-complement output domain
    localparam logic [X_W-1:0] X_SAT_POS = 21'h0FFFFF;
    localparam logic [X_W-1:0] X_SAT_NEG = 21'h100000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2,
        ROUND  = 2'd3
    } state_t;

endpackage : nlc_pkg
`default_nettype wire

// File: rtl/smc_float_unpack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : smc_float_unpack                                             |
// | Description : Combinational decode of a 32-bit sign-magnitude float into   |
// |               sign, unbiased exponent k, 24-bit mantissa and class flags.  |
// | Ports       : i_y          SMC float word                                  |
// |               o_sign       sign bit                                        |
// |               o_k          unbiased exponent (E-127), signed               |
// |               o_m          mantissa with hidden one                        |
// |               o_zero       E==0 (zero and denormals)                       |
// |               o_infnan     E==255                                          |
// |               o_underflow  k < -1, rounds to zero                          |
// |               o_overflow   k >= 20, saturates (excludes exact minimum)     |
// |               o_exact_min  -2^20 exactly, representable                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module smc_float_unpack
    import nlc_pkg::*;
(
    input  logic [SMC_W-1:0] i_y,
    output logic             o_sign,
    output logic signed [8:0] o_k,
    output logic [23:0]      o_m,
    output logic             o_zero,
    output logic             o_infnan,
    output logic             o_underflow,
    output logic             o_overflow,
    output logic             o_exact_min
);

    logic [7:0]        w_exp;
    logic [22:0]       w_frac;
    logic signed [8:0] w_k;
    logic              w_exact_min;

    assign w_exp  = i_y[30:23];
    assign w_frac = i_y[22:0];
    assign w_k    = $signed({1'b0, w_exp} - 9'(SMC_EXP_BIAS));

    // -2^20 is the only k==20 value that still fits the output range
    assign w_exact_min = i_y[31] && (w_k == 9'sd20) && (w_frac == 23'd0);

    assign o_sign      = i_y[31];
    assign o_k         = w_k;
    assign o_m         = {1'b1, w_frac};
    assign o_zero      = (w_exp == 8'd0);
    assign o_infnan    = (w_exp == 8'hFF);
    assign o_underflow = (w_exp != 8'd0) && (w_k < -9'sd1);
    assign o_overflow  = (w_exp != 8'hFF) && (w_k >= 9'sd20) && !w_exact_min;
    assign o_exact_min = w_exact_min;

endmodule : smc_float_unpack
`default_nettype wire

// File: rtl/smc_float_to_fixed.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : smc_float_to_fixed                                           |
// | Description : Converts an SMC float voltage into a 21-bit two's-complement |
// |               ADC count, rounding half away from zero and saturating.      |
// |               Normal values are shifted right one bit per cycle.           |
// | Ports       : i_clk     clock                                              |
// |               i_reset   asynchronous active-low reset                      |
// |               i_y       SMC float input, sampled at capture only           |
// |               i_srdyi   input valid, ignored while busy                    |
// |               o_x       result count, held until the next result           |
// |               o_srdyo   one-cycle pulse marking a new o_x                  |
// |               o_sat     saturation flag, held with o_x                     |
// |               o_busy    high whenever a conversion is in flight            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module smc_float_to_fixed
    import nlc_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [SMC_W-1:0] i_y,
    input  logic             i_srdyi,
    output logic [X_W-1:0]   o_x,
    output logic             o_srdyo,
    output logic             o_sat,
    output logic             o_busy
);

    // Decoded input
    logic              w_sign;
    logic signed [8:0] w_k;
    logic [23:0]       w_m;
    logic              w_zero;
    logic              w_infnan;
    logic              w_underflow;
    logic              w_overflow;
    logic              w_exact_min;
    logic [4:0]        w_shift;

    // State and datapath
    state_t            r_state_q,   w_state_d;
    logic [23:0]       r_acc_q,     w_acc_d;
    logic [4:0]        r_cnt_q,     w_cnt_d;
    logic              r_sign_q,    w_sign_d;
    logic [X_W-1:0]    r_fx_q,      w_fx_d;
    logic              r_fsat_q,    w_fsat_d;
    logic [X_W-1:0]    r_x_q,       w_x_d;
    logic              r_sat_q,     w_sat_d;
    logic              r_srdyo_q,   w_srdyo_d;

    // Rounding
    logic [24:0]       w_rnd;

    smc_float_unpack u_unpack (
        .i_y         (i_y),
        .o_sign      (w_sign),
        .o_k         (w_k),
        .o_m         (w_m),
        .o_zero      (w_zero),
        .o_infnan    (w_infnan),
        .o_underflow (w_underflow),
        .o_overflow  (w_overflow),
        .o_exact_min (w_exact_min)
    );

    // s = 22-k leaves one fractional bit in acc; only -1..19 reach here (3..23)
    assign w_shift = 5'(9'sd22 - w_k);

    // Half away from zero: add half an LSB to the magnitude, drop the fraction
    assign w_rnd = ({1'b0, r_acc_q} + 25'd1) >> 1;

    always_comb begin
        w_state_d = r_state_q;
        w_acc_d   = r_acc_q;
        w_cnt_d   = r_cnt_q;
        w_sign_d  = r_sign_q;
        w_fx_d    = r_fx_q;
        w_fsat_d  = r_fsat_q;
        w_x_d     = r_x_q;
        w_sat_d   = r_sat_q;
        w_srdyo_d = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (i_srdyi) begin
                    w_sign_d  = w_sign;
                    w_state_d = FINISH;
                    if (w_zero || w_underflow) begin
                        w_fx_d   = '0;
                        w_fsat_d = 1'b0;
                    end else if (w_exact_min) begin
                        w_fx_d   = X_SAT_NEG;
                        w_fsat_d = 1'b0;
                    end else if (w_infnan || w_overflow) begin
                        w_fx_d   = w_sign ? X_SAT_NEG : X_SAT_POS;
                        w_fsat_d = 1'b1;
                    end else begin
                        w_acc_d   = w_m;
                        w_cnt_d   = w_shift;
                        w_state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_acc_d = r_acc_q >> 1;
                w_cnt_d = r_cnt_q - 5'd1;
                if (r_cnt_q == 5'd1) begin
                    w_state_d = ROUND;
                end
            end
            ROUND: begin
                // A negative magnitude is at most 2^20, so only positive saturates
                if (r_sign_q) begin
                    w_x_d   = X_W'(-w_rnd);
                    w_sat_d = 1'b0;
                end else if (w_rnd > 25'(X_MAX)) begin
                    w_x_d   = X_SAT_POS;
                    w_sat_d = 1'b1;
                end else begin
                    w_x_d   = X_W'(w_rnd);
                    w_sat_d = 1'b0;
                end
                w_srdyo_d = 1'b1;
                w_state_d = IDLE;
            end
            FINISH: begin
                w_x_d     = r_fx_q;
                w_sat_d   = r_fsat_q;
                w_srdyo_d = 1'b1;
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state_q <= IDLE;
            r_acc_q   <= '0;
            r_cnt_q   <= '0;
            r_sign_q  <= 1'b0;
            r_fx_q    <= '0;
            r_fsat_q  <= 1'b0;
            r_x_q     <= '0;
            r_sat_q   <= 1'b0;
            r_srdyo_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_acc_q   <= w_acc_d;
            r_cnt_q   <= w_cnt_d;
            r_sign_q  <= w_sign_d;
            r_fx_q    <= w_fx_d;
            r_fsat_q  <= w_fsat_d;
            r_x_q     <= w_x_d;
            r_sat_q   <= w_sat_d;
            r_srdyo_q <= w_srdyo_d;
        end
    end

    assign o_x     = r_x_q;
    assign o_sat   = r_sat_q;
    assign o_srdyo = r_srdyo_q;
    assign o_busy  = (r_state_q != IDLE);

endmodule : smc_float_to_fixed
`default_nettype wire
